// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: widths, fetch FSM states and opcodes.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Major opcodes consumed by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO holding {pc, instruction} pairs; head reads 0 when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot, so push-while-full is fine when paired with a pop
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers in-order responses.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [XLEN+ILEN-1:0] fifo_head;
  logic [CW:0]          in_use;
  logic                 req_fire;
  logic                 rsp_keep;
  logic [CW-1:0]        drop_next;

  // Every slot is either in flight or buffered, so the FIFO can never overflow
  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && (state == FETCH) && !redirect_valid && !fifo_full
                          && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign drop_next      = outstanding - CW'(imem_rsp_valid);

  assign inst_valid              = !fifo_empty;
  assign {inst_pc, instruction}  = fifo_head;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + ILEN)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (inst_valid && inst_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight, minus a response landing now, belongs to the old path
      fetch_pc    <= align_pc(redirect_pc);
      rsp_pc      <= align_pc(redirect_pc);
      outstanding <= drop_next;
      drop_cnt    <= drop_next;
      state       <= (drop_next != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                rsp_pc   <= rsp_pc + PC_STEP;
      end
      if (state == DRAIN && drop_cnt == '0) state <= FETCH;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench: behavioural imem (L=1, holdable) plus a delivery scoreboard on the decoder side.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int          total = 0;
  int          bad = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] exp_pc[$];
  logic [31:0] mon_exp;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: responds one cycle after acceptance unless held, strictly in order
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
  end

  initial begin : mem_model
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (!rst_n) pend.delete();
      else if (!mem_hold && pend.size() > 0) begin
        a = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(a);
      end
    end
  end

  // Scoreboard monitor: every decoder handshake must match the next expected PC
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      total++;
      if (exp_pc.size() == 0) begin
        bad++;
        $display("FAIL unexpected_delivery: got pc=%h insn=%h, required no delivery", inst_pc, instruction);
      end else begin
        mon_exp = exp_pc.pop_front();
        if (inst_pc !== mon_exp || instruction !== word_of(mon_exp)) begin
          bad++;
          $display("FAIL delivery: got pc=%h insn=%h, required pc=%h insn=%h",
                   inst_pc, instruction, mon_exp, word_of(mon_exp));
        end else begin
          $display("deliver pc=%h insn=%h ok", inst_pc, instruction);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    exp_pc.delete();
    repeat (3) step();
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        check(name, imem_req_addr, addr);
        found = 1'b1;
      end
      step();
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: got no request within 40 cycles, required addr=%h", name, addr);
    end
  endtask

  task automatic consume(input string name, input int n, input logic [31:0] start);
    for (int k = 0; k < n; k++) exp_pc.push_back(start + 32'(4 * k));
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && exp_pc.size() > 0; i++) step();
    inst_ready = 1'b0;
    total++;
    if (exp_pc.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d undelivered, required 0", name, exp_pc.size());
      exp_pc.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // Streaming after reset, L=1, decoder always ready
    imem_req_ready = 1'b1;
    mem_hold = 1'b0;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_pc.push_back(32'(4 * k));
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 32'h0);
    step();
    @(negedge clk);
    check("first_latency_inst_valid", inst_valid, 0);
    check("second_req_addr", imem_req_addr, 32'h4);
    step();
    for (int k = 2; k < 10; k++) begin
      @(negedge clk);
      check("throughput_inst_valid", inst_valid, 1);
      step();
    end
    inst_ready = 1'b0;
    check("stream_all_delivered", 32'(exp_pc.size()), 32'h0);

    // Decoder stalled: exactly DEPTH requests, then no more
    do_reset();
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) n++;
      step();
    end
    check("credit_requests", 32'(n), 32'd4);
    @(negedge clk);
    check("credit_stall_req_valid", imem_req_valid, 0);
    step();
    consume("stall_drain", 4, 32'h0);

    // Redirect to 0x103 with two requests outstanding
    imem_req_ready = 1'b0;
    mem_hold = 1'b1;
    do_reset();
    imem_req_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("redirect_cycle_no_req", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    imem_req_ready = 1'b1;
    wait_req("redirect_target_addr", 32'h0000_0100);
    consume("redirect_drop_stale", 2, 32'h0000_0100);

    // Redirect coinciding with the only outstanding response
    imem_req_ready = 1'b0;
    mem_hold = 1'b1;
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    mem_hold = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    imem_req_ready = 1'b1;
    @(negedge clk);
    check("rsp_redirect_no_req", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rsp_redirect_req_next", imem_req_valid, 1);
    check("rsp_redirect_addr", imem_req_addr, 32'h0000_0400);
    step();
    consume("rsp_redirect_discard", 2, 32'h0000_0400);

    // Back-to-back redirects while draining
    imem_req_ready = 1'b1;
    mem_hold = 1'b1;
    do_reset();
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    mem_hold = 1'b0;
    step();
    redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    wait_req("double_redirect_addr", 32'h0000_0300);
    consume("double_redirect_deliver", 3, 32'h0000_0300);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    wait_req("wrap_first_addr", 32'hFFFF_FFFC);
    wait_req("wrap_next_addr", 32'h0000_0000);
    consume("wrap_deliver", 3, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
